fetch_pc_sequencer: RTL and testbench

- Owns the F-stage program counter register and sequences next-PC selection for the 5-stage MIPS pipeline.
- Arbitrates between sequential fetch, D-stage redirects (branch / j / jr) and hazard-unit stalls.
- Holds fetch while a jr target is not yet forwardable.
- Sits between the hazard unit, the D-stage decoder/comparator and the instruction memory address port.

---
 rtl/fetch_pc_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: F-stage PC register and next-PC sequencing; FETCH_PERF_CNT_EN adds perf counters.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned JR_WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_br_take,
    input  logic        d_j,
    input  logic        d_jr,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_jr_target,
    input  logic        d_jr_ready,
    output logic [31:0] f_pc,
    output logic        jr_wait,
    output logic        redirect,
    output logic        addr_err,
    output logic        hang_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles
`endif
);
    typedef enum logic [0:0] {RUN, WAIT_JR} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        redirect_q, redirect_d;
    logic        addr_err_q, addr_err_d;
    logic        hang_q, hang_d;
    logic [31:0] br_tgt, j_tgt, jr_tgt;
    logic        misaligned;
    assign br_tgt     = d_pc + 32'd4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
    assign j_tgt      = {d_pc[31:28], d_imm26, 2'b00};
    assign jr_tgt     = {d_jr_target[31:2], 2'b00};
    assign misaligned = |d_jr_target[1:0];
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        addr_err_d = 1'b0;
        hang_d     = hang_q;
        if (state_q == RUN) begin
            if (stall) begin
                pc_d = pc_q;
            end else if (d_br_take || d_j) begin
                pc_d       = d_br_take ? br_tgt : j_tgt;
                redirect_d = 1'b1;
            end else if (d_jr && d_jr_ready) begin
                pc_d       = jr_tgt;
                redirect_d = 1'b1;
                addr_err_d = misaligned;
            end else if (d_jr) begin
                state_d = WAIT_JR;
                cnt_d   = 8'd1;
                hang_d  = hang_q | (cnt_d == 8'(JR_WAIT_MAX));
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else begin
            // stall is deliberately ignored here: jr_wait already freezes F/D
            if (d_jr && d_jr_ready) begin
                pc_d       = jr_tgt;
                redirect_d = 1'b1;
                addr_err_d = misaligned;
                state_d    = RUN;
                cnt_d      = 8'd0;
            end else if (!d_jr) begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end else begin
                cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                hang_d = hang_q | (cnt_d == 8'(JR_WAIT_MAX));
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            cnt_q      <= 8'd0;
            redirect_q <= 1'b0;
            addr_err_q <= 1'b0;
            hang_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            addr_err_q <= addr_err_d;
            hang_q     <= hang_d;
        end
    end
    assign f_pc     = pc_q;
    assign jr_wait  = state_q == WAIT_JR;
    assign redirect = redirect_q;
    assign addr_err = addr_err_q;
    assign hang_err = hang_q;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_red_q, perf_red_d, perf_stl_q, perf_stl_d;
    always_comb begin
        perf_red_d = perf_red_q + {31'd0, redirect_q};
        perf_stl_d = perf_stl_q + {31'd0, stall | jr_wait};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_red_q <= 32'd0;
            perf_stl_q <= 32'd0;
        end else begin
            perf_red_q <= perf_red_d;
            perf_stl_q <= perf_stl_d;
        end
    end
    assign perf_redirects    = perf_red_q;
    assign perf_stall_cycles = perf_stl_q;
`endif
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed vectors with a queued scoreboard checked after every clock edge.
module tb_fetch_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, d_br_take = 1'b0, d_j = 1'b0, d_jr = 1'b0, d_jr_ready = 1'b0;
    logic [31:0] d_pc = 32'd0, d_jr_target = 32'd0;
    logic [25:0] d_imm26 = 26'd0;
    logic [31:0] f_pc;
    logic        jr_wait, redirect, addr_err, hang_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects, perf_stall_cycles;
`endif
    typedef struct packed {
        logic [31:0] pc;
        logic        jw;
        logic        red;
        logic        ae;
        logic        hang;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    fetch_pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .d_br_take(d_br_take), .d_j(d_j), .d_jr(d_jr),
        .d_pc(d_pc), .d_imm26(d_imm26), .d_jr_target(d_jr_target), .d_jr_ready(d_jr_ready),
        .f_pc(f_pc), .jr_wait(jr_wait), .redirect(redirect), .addr_err(addr_err), .hang_err(hang_err)
`ifdef FETCH_PERF_CNT_EN
        , .perf_redirects(perf_redirects), .perf_stall_cycles(perf_stall_cycles)
`endif
    );
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{f_pc, jr_wait, redirect, addr_err, hang_err};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d: got pc=%h jw=%b red=%b ae=%b hang=%b, want pc=%h jw=%b red=%b ae=%b hang=%b",
                         vectors, a.pc, a.jw, a.red, a.ae, a.hang, e.pc, e.jw, e.red, e.ae, e.hang);
            end
        end
    end
    task automatic step(input logic rs, st, br, j, jr, rdy, input logic [31:0] pc,
                        input logic [25:0] imm, input logic [31:0] tgt, input exp_t e);
        @(negedge clk);
        reset = rs; stall = st; d_br_take = br; d_j = j; d_jr = jr; d_jr_ready = rdy;
        d_pc = pc; d_imm26 = imm; d_jr_target = tgt;
        q.push_back(e);
    endtask
    task automatic idle(input exp_t e);
        step(0, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0, e);
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0, '{32'h3000, 0, 0, 0, 0});
        idle('{32'h3004, 0, 0, 0, 0});
        idle('{32'h3008, 0, 0, 0, 0});
        idle('{32'h300C, 0, 0, 0, 0});
        // backward branch: 0x3010 + 4 - 16
        step(0, 0, 1, 0, 0, 0, 32'h3010, 26'h000FFFC, 32'd0, '{32'h3004, 0, 1, 0, 0});
        idle('{32'h3008, 0, 0, 0, 0});
        // j beats a ready jr
        step(0, 0, 0, 1, 1, 1, 32'h3020, 26'h0000C40, 32'h3206, '{32'h3100, 0, 1, 0, 0});
        idle('{32'h3104, 0, 0, 0, 0});
        step(0, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h3206, '{32'h3104, 1, 0, 0, 0});
        step(0, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h3206, '{32'h3104, 1, 0, 0, 0});
        step(0, 1, 0, 0, 1, 0, 32'd0, 26'd0, 32'h3206, '{32'h3104, 1, 0, 0, 0});
        step(0, 1, 0, 0, 1, 1, 32'd0, 26'd0, 32'h3206, '{32'h3204, 0, 1, 1, 0});
        idle('{32'h3208, 0, 0, 0, 0});
        step(0, 1, 1, 0, 0, 0, 32'h3010, 26'h000FFFC, 32'd0, '{32'h3208, 0, 0, 0, 0});
        step(0, 1, 1, 0, 0, 0, 32'h3010, 26'h000FFFC, 32'd0, '{32'h3208, 0, 0, 0, 0});
        step(0, 0, 1, 0, 0, 0, 32'h3010, 26'h000FFFC, 32'd0, '{32'h3004, 0, 1, 0, 0});
        idle('{32'h3008, 0, 0, 0, 0});
        // branch beats j: 0x3024 + 0x3100
        step(0, 0, 1, 1, 0, 0, 32'h3020, 26'h0000C40, 32'd0, '{32'h6124, 0, 1, 0, 0});
        // aligned jr to top of memory, then sequential wrap
        step(0, 0, 0, 0, 1, 1, 32'd0, 26'd0, 32'hFFFF_FFFC, '{32'hFFFF_FFFC, 0, 1, 0, 0});
        idle('{32'h0000_0000, 0, 0, 0, 0});
        // jr dropped while waiting: no redirect, PC held that cycle
        step(0, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h4000, '{32'h0000_0000, 1, 0, 0, 0});
        idle('{32'h0000_0000, 0, 0, 0, 0});
        idle('{32'h0000_0004, 0, 0, 0, 0});
        for (int k = 1; k <= 10; k++)
            step(0, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h4000, '{32'h0000_0004, 1, 0, 0, k >= 8});
        step(1, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h4000, '{32'h3000, 0, 0, 0, 0});
        idle('{32'h3004, 0, 0, 0, 0});
        for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
